// File: rtl/adc_capture_packer.sv
// adc_capture_fifo: first-word-fall-through buffer carrying {last, data} words for the capture packer.
// Latency: a word written at edge n is visible on rd_vld/rd_dat right after edge n.
// Backpressure: wr_rdy drops only when full and no pop is happening in the same cycle.
//
// Ports: clk_i/rst_i clock and async active-high reset; wr_* write side; rd_* read side;
//        empty_nxt reports that the FIFO will be empty after the coming clock edge.
module adc_capture_fifo #(
    parameter int W  = 33,
    parameter int AW = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat,
    input  logic         rd_rdy,
    output logic         empty_nxt
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  wptr_nxt;
    logic [AW:0]  rptr_nxt;
    logic         full;
    logic         empty;
    logic         wr_en;
    logic         rd_en;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wptr == rptr);
    assign full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd_vld    = !empty;
    assign rd_en     = rd_vld && rd_rdy;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a write.
    assign wr_rdy    = !full || rd_en;
    assign wr_en     = wr_vld && wr_rdy;
    assign wptr_nxt  = wptr + (AW+1)'(wr_en);
    assign rptr_nxt  = rptr + (AW+1)'(rd_en);
    assign empty_nxt = (wptr_nxt == rptr_nxt);
    assign rd_dat    = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr_nxt;
            rptr <= rptr_nxt;
        end
    end

    // Storage needs no reset: contents are only observed while pointers say valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wptr[AW-1:0]] <= wr_dat;
        end
    end
endmodule

// adc_capture_packer: captures len DDR ADC words, converts both 12-bit samples to signed 16-bit, packs into 32 bits.
// Latency: sample at edge n, conversion register, FIFO write at edge n+1, word visible right after that edge.
// Backpressure: m_ready_i low fills the FIFO; writes into a full FIFO are dropped and flagged on overflow_o.
//
// Ports: clk_i/rst_i clock and async active-high reset; data_i DDR word ({rise, fall});
//        arm_i/len_i start a capture of len_i words; m_data_o/m_valid_o/m_ready_i/m_last_o output stream;
//        busy_o capture or drain in progress; overflow_o sticky drop flag, cleared by the next accepted arm.
module adc_capture_packer #(
    parameter int OFFSET_BINARY = 1,
    parameter int DEPTH_LOG2    = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] data_i,
    input  logic        arm_i,
    input  logic [15:0] len_i,
    output logic [31:0] m_data_o,
    output logic        m_valid_o,
    input  logic        m_ready_i,
    output logic        m_last_o,
    output logic        busy_o,
    output logic        overflow_o
);
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [31:0] conv_dat;
    logic        conv_vld;
    logic        conv_last;
    logic        arm_acc;
    logic        sample;
    logic        fifo_wr_rdy;
    logic        fifo_rd_vld;
    logic [32:0] fifo_rd_dat;
    logic        fifo_empty_nxt;

    // Offset-binary to two's complement is just an MSB flip, then sign-extend.
    function automatic logic [15:0] to_s16(input logic [11:0] s);
        logic [11:0] t;
        t = (OFFSET_BINARY != 0) ? (s ^ 12'h800) : s;
        return {{4{t[11]}}, t};
    endfunction

    assign arm_acc = (state == IDLE) && arm_i && (len_i != 16'd0);
    assign sample  = (state == CAPTURE);
    assign busy_o  = (state != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cnt holds the words still to sample, so cnt==1 marks the final sample.
    // DRAIN waits for the last converted word to be written, then leaves on the
    // edge that empties the FIFO.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (arm_acc) state_nxt = CAPTURE;
            CAPTURE: if (cnt == 16'd1) state_nxt = DRAIN;
            DRAIN:   if (!conv_vld && fifo_empty_nxt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt        <= '0;
            conv_dat   <= '0;
            conv_vld   <= 1'b0;
            conv_last  <= 1'b0;
            overflow_o <= 1'b0;
        end else begin
            conv_vld <= sample;
            if (arm_acc) begin
                cnt <= len_i;
            end else if (sample) begin
                cnt <= cnt - 16'd1;
            end
            if (sample) begin
                conv_dat  <= {to_s16(data_i[23:12]), to_s16(data_i[11:0])};
                conv_last <= (cnt == 16'd1);
            end
            // The counter keeps running on a drop, so capture duration is fixed by len.
            if (arm_acc) begin
                overflow_o <= 1'b0;
            end else if (conv_vld && !fifo_wr_rdy) begin
                overflow_o <= 1'b1;
            end
        end
    end

    adc_capture_fifo #(
        .W  (33),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_vld    (conv_vld),
        .wr_dat    ({conv_last, conv_dat}),
        .wr_rdy    (fifo_wr_rdy),
        .rd_vld    (fifo_rd_vld),
        .rd_dat    (fifo_rd_dat),
        .rd_rdy    (m_ready_i),
        .empty_nxt (fifo_empty_nxt)
    );

    // Gate the read port so outputs read as zero whenever nothing is buffered.
    assign m_valid_o = fifo_rd_vld;
    assign m_data_o  = fifo_rd_vld ? fifo_rd_dat[31:0] : 32'd0;
    assign m_last_o  = fifo_rd_vld && fifo_rd_dat[32];
endmodule

// File: tb/tb_adc_capture_packer.sv
// Bench for adc_capture_packer: two instances (offset-binary and two's-complement input)
// share all stimulus; a scoreboard queue holds expected words, a negedge monitor pops them.
`timescale 1ns/1ps
module tb_adc_capture_packer;
    localparam int DEPTH_LOG2 = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [23:0] data_i;
    logic        arm_i;
    logic [15:0] len_i;
    logic        m_ready_i;

    logic [31:0] d1_data, d0_data;
    logic        v1, v0, l1, l0, b1, b0, o1, o0;

    always #5 clk = ~clk;

    adc_capture_packer #(.OFFSET_BINARY(1), .DEPTH_LOG2(DEPTH_LOG2)) dut_ob1 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .arm_i(arm_i), .len_i(len_i),
        .m_data_o(d1_data), .m_valid_o(v1), .m_ready_i(m_ready_i), .m_last_o(l1),
        .busy_o(b1), .overflow_o(o1));

    adc_capture_packer #(.OFFSET_BINARY(0), .DEPTH_LOG2(DEPTH_LOG2)) dut_ob0 (
        .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .arm_i(arm_i), .len_i(len_i),
        .m_data_o(d0_data), .m_valid_o(v0), .m_ready_i(m_ready_i), .m_last_o(l0),
        .busy_o(b0), .overflow_o(o0));

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d0;
        logic        last;
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    int          n_vec = 0;
    int          n_err = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [31:0] pd = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference conversion in plain integer arithmetic.
    function automatic logic [15:0] ref_s16(input int s, input bit ob);
        int v;
        if (ob) v = s - 2048;
        else    v = (s >= 2048) ? s - 4096 : s;
        return v[15:0];
    endfunction

    function automatic logic [31:0] ref_word(input logic [23:0] d, input bit ob);
        return {ref_s16(int'(d[23:12]), ob), ref_s16(int'(d[11:0]), ob)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int j, input int stall, input int rmode);
        if (j <= stall)      m_ready_i = 1'b0;
        else if (rmode == 0) m_ready_i = 1'b1;
        else if (rmode == 1) m_ready_i = j[0];
        else                 m_ready_i = 1'($urandom_range(0, 1));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_valid"},    64'({v1, v0}), 64'd0);
        check({tag, "_last"},     64'({l1, l0}), 64'd0);
        check({tag, "_busy"},     64'({b1, b0}), 64'd0);
        check({tag, "_overflow"}, 64'({o1, o0}), 64'd0);
        check({tag, "_data"},     64'({d1_data, d0_data}), 64'd0);
    endtask

    task automatic do_reset_mid();
        rst_i = 1'b1;
        #1;
        check_quiet("rst_mid");
        expq.delete();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // One capture: arm, feed len words, then drain until busy falls.
    // Words are predicted dropped when written into a full FIFO that has seen no pops.
    task automatic capture(input int len, input bit rnd, input logic [23:0] dfix,
                           input int rmode, input int stall, input bit lat,
                           input bit arm_mid, input bit arm_drain, input int rst_at);
        logic [23:0] d;
        exp_t        e;
        bit          ovf_exp;
        bit          done;
        logic        pvld;
        int          j;
        ovf_exp = 1'b0;
        done    = 1'b0;
        set_ready(0, stall, rmode);
        arm_i = 1'b1;
        len_i = 16'(len);
        tick();
        arm_i = 1'b0;
        len_i = 16'($urandom);
        check("busy_after_arm", 64'({b1, b0}), 64'd3);
        for (int i = 0; i < len; i++) begin
            d      = rnd ? 24'($urandom) : dfix;
            data_i = d;
            set_ready(i + 1, stall, rmode);
            if (arm_mid && i == 1) begin
                arm_i = 1'b1;
                len_i = 16'd7;
            end
            if (i >= DEPTH && i + 2 <= stall) begin
                ovf_exp = 1'b1;
            end else begin
                e.d1   = ref_word(d, 1'b1);
                e.d0   = ref_word(d, 1'b0);
                e.last = (i == len - 1);
                expq.push_back(e);
            end
            tick();
            arm_i = 1'b0;
            if (lat && i == 0) check("first_word_not_yet", 64'(v1), 64'd0);
            if (lat && i == 1) check("first_word_visible", 64'(v1), 64'd1);
            if (rst_at != 0 && i == rst_at - 1) begin
                do_reset_mid();
                return;
            end
        end
        data_i = 24'($urandom);
        j = len + 1;
        for (int c = 0; c < 500 && !done; c++) begin
            set_ready(j, stall, rmode);
            j++;
            if (arm_drain && c == 0) begin
                arm_i = 1'b1;
                len_i = 16'd5;
            end
            pvld = v1;
            tick();
            arm_i = 1'b0;
            if (!b1) begin
                done = 1'b1;
                check("busy_fall_at_last_pop", 64'(pvld), 64'd1);
            end
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: busy still high after 500 cycles, expected idle");
        end
        check("idle_busy",  64'({b1, b0}), 64'd0);
        check("idle_valid", 64'({v1, v0}), 64'd0);
        check("words_left", 64'(expq.size()), 64'd0);
        check("overflow",   64'({o1, o0}), ovf_exp ? 64'd3 : 64'd0);
    endtask

    // Monitor: compares on every handshake, and checks hold-stability while stalled.
    always @(negedge clk) begin
        if (rst_i) begin
            pv = 1'b0;
        end else begin
            if (pv && !pr) begin
                check("stall_valid", 64'(v1), 64'd1);
                check("stall_data",  64'(d1_data), 64'(pd));
                check("stall_last",  64'(l1), 64'(pl));
            end
            if (v1 || v0) begin
                check("valid_pair", 64'(v0), 64'(v1));
                if (m_ready_i) begin
                    if (expq.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected no word at %0t", d1_data, $time);
                    end else begin
                        mon_e = expq.pop_front();
                        check("data_ob1", 64'(d1_data), 64'(mon_e.d1));
                        check("data_ob0", 64'(d0_data), 64'(mon_e.d0));
                        check("last",     64'({l1, l0}), mon_e.last ? 64'd3 : 64'd0);
                    end
                end
            end
            pv = v1;
            pr = m_ready_i;
            pd = d1_data;
            pl = l1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        rst_i     = 1'b1;
        arm_i     = 1'b0;
        len_i     = 16'd0;
        data_i    = 24'd0;
        m_ready_i = 1'b0;
        #1;
        check_quiet("reset");
        tick();
        tick();
        rst_i = 1'b0;

        capture(4, 1'b0, 24'h800FFF, 0, 0, 1'b1, 1'b0, 1'b0, 0);
        capture(2, 1'b0, 24'h8007FF, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        capture(3, 1'b1, 24'h0, 1, 0, 1'b0, 1'b0, 1'b0, 0);
        capture(20, 1'b1, 24'h0, 0, 21, 1'b0, 1'b0, 1'b1, 0);

        // Zero-length arm: ignored, and the sticky overflow from above survives it.
        arm_i = 1'b1;
        len_i = 16'd0;
        tick();
        arm_i = 1'b0;
        check("len0_busy", 64'({b1, b0}), 64'd0);
        check("len0_overflow_kept", 64'({o1, o0}), 64'd3);
        tick();
        check("len0_still_idle", 64'({b1, b0, v1, v0}), 64'd0);

        capture(17, 1'b1, 24'h0, 0, 17, 1'b0, 1'b0, 1'b0, 0);
        capture(6, 1'b1, 24'h0, 2, 0, 1'b0, 1'b1, 1'b0, 0);
        capture(10, 1'b1, 24'h0, 0, 0, 1'b0, 1'b0, 1'b0, 5);
        capture(2, 1'b1, 24'h0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        capture(1, 1'b1, 24'h0, 1, 0, 1'b0, 1'b0, 1'b0, 0);
        for (int r = 0; r < 6; r++) begin
            capture(int'($urandom_range(1, 16)), 1'b1, 24'h0, int'($urandom_range(0, 2)),
                    0, 1'b0, 1'b0, 1'b0, 0);
        end
        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_capture_packer.md
ADC_CAPTURE_PACKER -- requirements
Module: adc_capture_packer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock port `clk_i`, reset port `rst_i`.
REQ-002 Parameters, one per line:
- OFFSET_BINARY, default 1: 1 = input samples are offset-binary and are converted to two's complement; 0 = input is already two's complement.
- DEPTH_LOG2, default 4: output FIFO depth is 2^DEPTH_LOG2 words.
REQ-003 Ports, one per line:
- clk_i  in  1  capture clock; all logic in this domain.
- rst_i  in  1  asynchronous active-high reset.
- data_i  in  24  DDR-captured ADC word; [23:12] rising-edge sample, [11:0] falling-edge sample.
- arm_i  in  1  start-capture pulse, acted on only in IDLE.
- len_i  in  16  capture length in words, sampled when arm_i is accepted.
- m_data_o  out  32  packed output word.
- m_valid_o  out  1  output word available.
- m_ready_i  in  1  downstream accepts the word.
- m_last_o  out  1  marks the final word of a capture.
- busy_o  out  1  high in CAPTURE or DRAIN.
- overflow_o  out  1  sticky flag: at least one word dropped this capture.

Function
REQ-004 State machine states SHALL be IDLE, CAPTURE and DRAIN.
- IDLE->CAPTURE on arm_i=1 with len_i!=0; arm_i with len_i=0 SHALL be ignored.
- CAPTURE->DRAIN after len words have been sampled.
- DRAIN->IDLE on the cycle the FIFO becomes empty.
REQ-005 arm_i SHALL be ignored in CAPTURE and DRAIN.
REQ-006 Acceptance timing: arm accepted at edge k; data_i sampled at edges k+1 .. k+len, one word per clock, no gaps.
REQ-007 Sample conversion, per 12-bit sample s:
- t = s XOR 12'h800 when OFFSET_BINARY=1, else t = s;
- output value is t sign-extended to 16 bits.
REQ-008 Packing: m_data_o[31:16] = converted data_i[23:12]; m_data_o[15:0] = converted data_i[11:0].
REQ-009 Pipeline: one conversion register stage, then FIFO write; data sampled at edge n SHALL be written into the FIFO at edge n+1.
REQ-010 FIFO behaviour:
- first-word fall-through; m_valid_o = FIFO not empty;
- with a continuously asserted m_ready_i, the first word SHALL be visible on m_valid_o after edge k+2.
REQ-011 Handshake:
- a word is popped on a clock edge where m_valid_o=1 and m_ready_i=1;
- m_data_o and m_last_o SHALL remain stable while m_valid_o=1 and m_ready_i=0.
REQ-012 The last flag SHALL be stored with each word; it is 1 only for the word sampled at edge k+len.
REQ-013 Write into a full FIFO:
- the word SHALL be dropped and overflow_o set;
- the capture count still advances, so capture length in time is unchanged;
- if the dropped word is the last word, no m_last_o is produced for that capture.
REQ-014 Simultaneous write and pop with the FIFO full SHALL succeed without a drop, since the pop frees the slot in the same cycle.
REQ-015 Pointer arithmetic:
- read/write pointers are DEPTH_LOG2+1 bits and wrap modulo 2^(DEPTH_LOG2+1);
- full = MSBs differ and the remaining bits are equal;
- empty = pointers equal.
REQ-016 overflow_o SHALL be cleared only on the next accepted arm or on reset.
REQ-017 The capture counter SHALL be 16 bits; len_i=16'hFFFF SHALL capture 65535 words.

Reset
REQ-018 On rst_i=1, asynchronously:
- state = IDLE; FIFO pointers = 0;
- m_valid_o=0, m_last_o=0, busy_o=0, overflow_o=0;
- conversion register = 0, so m_data_o=0.
REQ-019 Reset asserted mid-capture SHALL discard all buffered words; no partial word or m_last_o SHALL appear after release.
REQ-020 After reset is released, the first clock edge SHALL be able to accept arm_i.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- OFFSET_BINARY=1, len=4, m_ready_i=1, data_i=24'h800_FFF -> 4 words 32'h0000_07FF; m_last_o on 4th word only; busy_o falls after the last pop.
- OFFSET_BINARY=0, data_i=24'h800_7FF -> 32'hF800_07FF.
- DEPTH_LOG2=4, len=20, m_ready_i=0 during capture -> 16 words retained, overflow_o=1, no m_last_o; after m_ready_i=1 the FIFO drains and the block returns to IDLE.
- len=3, m_ready_i toggled every cycle -> words delivered in order, m_data_o stable while stalled, m_last_o on word 3.
- arm_i pulsed during CAPTURE, and arm_i with len=0 in IDLE -> both ignored; state and counters unchanged.
- rst_i asserted at the 5th word of a len=10 capture -> m_valid_o=0 immediately; after release, a new len=2 capture produces exactly 2 words.
